// File: rtl/element_tree_builder_if.sv
// Bus between the element/attribute parser and the tree builder.
// The parser side uses the master modport and the builder uses the slave modport.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 3
`endif
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 8
`endif
`ifndef TAG_DIV
`define TAG_DIV  3'd1
`define TAG_P    3'd2
`define TAG_BODY 3'd3
`define TAG_A    3'd4
`define TAG_IMG  3'd5
`endif

interface element_tree_builder_if #(
    parameter int MAX_DEPTH = 8,
    parameter int NODE_BITS = 6
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    logic                              elem_valid;
    logic [`ELE_TAG_BITES-1:0]         element_tag;
    logic                              is_closing_tag;
    logic                              attr_valid;
    logic [`ATTRIBUTE_TYPE_BITES-1:0]  attribute_type;
    logic [`ATTRIBUTE_VAL_BITES-1:0]   attribute_value;

    logic                              node_valid;
    logic [`ELE_TAG_BITES-1:0]         node_tag;
    logic [NODE_BITS-1:0]              node_index;
    logic [NODE_BITS-1:0]              node_parent;
    logic [DEPTH_W-1:0]                node_depth;
    logic                              close_valid;
    logic [NODE_BITS-1:0]              close_index;
    logic                              attr_out_valid;
    logic [NODE_BITS-1:0]              attr_owner;
    logic [`ATTRIBUTE_TYPE_BITES-1:0]  attr_out_type;
    logic [`ATTRIBUTE_VAL_BITES-1:0]   attr_out_value;
    logic [DEPTH_W-1:0]                depth;
    logic                              doc_done;
    logic                              err_overflow;
    logic                              err_underflow;
    logic                              err_mismatch;

    modport master (
        output elem_valid, element_tag, is_closing_tag,
        output attr_valid, attribute_type, attribute_value,
        input  node_valid, node_tag, node_index, node_parent, node_depth,
        input  close_valid, close_index,
        input  attr_out_valid, attr_owner, attr_out_type, attr_out_value,
        input  depth, doc_done, err_overflow, err_underflow, err_mismatch
    );

    modport slave (
        input  elem_valid, element_tag, is_closing_tag,
        input  attr_valid, attribute_type, attribute_value,
        output node_valid, node_tag, node_index, node_parent, node_depth,
        output close_valid, close_index,
        output attr_out_valid, attr_owner, attr_out_type, attr_out_value,
        output depth, doc_done, err_overflow, err_underflow, err_mismatch
    );
endinterface

// File: rtl/element_tree_builder.sv
// Builds a document tree from parsed tag/attribute pulses: numbers nodes, tracks
// parents on an open-element stack, and flags structural errors.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 3
`endif
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 8
`endif
`ifndef TAG_DIV
`define TAG_DIV  3'd1
`define TAG_P    3'd2
`define TAG_BODY 3'd3
`define TAG_A    3'd4
`define TAG_IMG  3'd5
`endif

module element_tree_builder #(
    parameter int MAX_DEPTH = 8,
    parameter int NODE_BITS = 6
) (
    input  logic                    clock,
    input  logic                    reset_n,
    element_tree_builder_if.slave   bus
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    localparam int PTR_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam int TAG_W   = `ELE_TAG_BITES;
    localparam int ATYP_W  = `ATTRIBUTE_TYPE_BITES;
    localparam int AVAL_W  = `ATTRIBUTE_VAL_BITES;

    localparam logic [DEPTH_W-1:0]   FULL      = DEPTH_W'(MAX_DEPTH);
    localparam logic [NODE_BITS-1:0] NO_PARENT = '1;

    typedef enum logic [1:0] {RUN, DONE, ERROR} state_t;

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [NODE_BITS-1:0] node_count_q, node_count_d;
    logic [NODE_BITS-1:0] last_open_q, last_open_d;
    logic                 last_open_vld_q, last_open_vld_d;

    logic                 node_valid_q, node_valid_d;
    logic [TAG_W-1:0]     node_tag_q, node_tag_d;
    logic [NODE_BITS-1:0] node_index_q, node_index_d;
    logic [NODE_BITS-1:0] node_parent_q, node_parent_d;
    logic [DEPTH_W-1:0]   node_depth_q, node_depth_d;
    logic                 close_valid_q, close_valid_d;
    logic [NODE_BITS-1:0] close_index_q, close_index_d;
    logic                 attr_out_valid_q, attr_out_valid_d;
    logic [NODE_BITS-1:0] attr_owner_q, attr_owner_d;
    logic [ATYP_W-1:0]    attr_out_type_q, attr_out_type_d;
    logic [AVAL_W-1:0]    attr_out_value_q, attr_out_value_d;
    logic                 doc_done_q, doc_done_d;
    logic                 err_overflow_q, err_overflow_d;
    logic                 err_underflow_q, err_underflow_d;
    logic                 err_mismatch_q, err_mismatch_d;

    // Stack payload is pure data: occupancy lives in depth_q, so no reset is needed.
    logic [TAG_W-1:0]     stack_tag_q [MAX_DEPTH];
    logic [NODE_BITS-1:0] stack_idx_q [MAX_DEPTH];

    logic                 push_en;
    logic [PTR_W-1:0]     push_ptr;
    logic [PTR_W-1:0]     top_ptr;
    logic [TAG_W-1:0]     top_tag;
    logic [NODE_BITS-1:0] top_idx;
    logic                 stack_empty;

    assign push_ptr    = PTR_W'(depth_q);
    assign top_ptr     = PTR_W'(depth_q - 1'b1);
    assign top_tag     = stack_tag_q[top_ptr];
    assign top_idx     = stack_idx_q[top_ptr];
    assign stack_empty = (depth_q == '0);

    always_comb begin
        state_d          = state_q;
        depth_d          = depth_q;
        node_count_d     = node_count_q;
        last_open_d      = last_open_q;
        last_open_vld_d  = last_open_vld_q;
        node_valid_d     = 1'b0;
        node_tag_d       = node_tag_q;
        node_index_d     = node_index_q;
        node_parent_d    = node_parent_q;
        node_depth_d     = node_depth_q;
        close_valid_d    = 1'b0;
        close_index_d    = close_index_q;
        attr_out_valid_d = 1'b0;
        attr_owner_d     = attr_owner_q;
        attr_out_type_d  = attr_out_type_q;
        attr_out_value_d = attr_out_value_q;
        doc_done_d       = doc_done_q;
        err_overflow_d   = err_overflow_q;
        err_underflow_d  = err_underflow_q;
        err_mismatch_d   = err_mismatch_q;
        push_en          = 1'b0;

        if (state_q == RUN) begin
            // Attribute uses last_open before any same-cycle element updates it.
            if (bus.attr_valid && last_open_vld_q) begin
                attr_out_valid_d = 1'b1;
                attr_owner_d     = last_open_q;
                attr_out_type_d  = bus.attribute_type;
                attr_out_value_d = bus.attribute_value;
            end

            if (bus.elem_valid) begin
                if (!bus.is_closing_tag) begin
                    if (bus.element_tag != `TAG_IMG && depth_q == FULL) begin
                        err_overflow_d = 1'b1;
                        state_d        = ERROR;
                    end else begin
                        node_valid_d    = 1'b1;
                        node_tag_d      = bus.element_tag;
                        node_index_d    = node_count_q;
                        node_depth_d    = depth_q;
                        node_parent_d   = stack_empty ? NO_PARENT : top_idx;
                        node_count_d    = node_count_q + 1'b1;
                        last_open_d     = node_count_q;
                        last_open_vld_d = 1'b1;
                        // Void elements are reported but never opened on the stack.
                        if (bus.element_tag != `TAG_IMG) begin
                            push_en = 1'b1;
                            depth_d = depth_q + 1'b1;
                        end
                    end
                end else if (stack_empty) begin
                    err_underflow_d = 1'b1;
                    state_d         = ERROR;
                end else if (bus.element_tag != top_tag) begin
                    err_mismatch_d = 1'b1;
                    state_d        = ERROR;
                end else begin
                    close_valid_d = 1'b1;
                    close_index_d = top_idx;
                    depth_d       = depth_q - 1'b1;
                    if (depth_q == DEPTH_W'(1) && top_tag == `TAG_BODY) begin
                        doc_done_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= RUN;
            depth_q          <= '0;
            node_count_q     <= '0;
            last_open_q      <= '0;
            last_open_vld_q  <= 1'b0;
            node_valid_q     <= 1'b0;
            node_tag_q       <= '0;
            node_index_q     <= '0;
            node_parent_q    <= '0;
            node_depth_q     <= '0;
            close_valid_q    <= 1'b0;
            close_index_q    <= '0;
            attr_out_valid_q <= 1'b0;
            attr_owner_q     <= '0;
            attr_out_type_q  <= '0;
            attr_out_value_q <= '0;
            doc_done_q       <= 1'b0;
            err_overflow_q   <= 1'b0;
            err_underflow_q  <= 1'b0;
            err_mismatch_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            depth_q          <= depth_d;
            node_count_q     <= node_count_d;
            last_open_q      <= last_open_d;
            last_open_vld_q  <= last_open_vld_d;
            node_valid_q     <= node_valid_d;
            node_tag_q       <= node_tag_d;
            node_index_q     <= node_index_d;
            node_parent_q    <= node_parent_d;
            node_depth_q     <= node_depth_d;
            close_valid_q    <= close_valid_d;
            close_index_q    <= close_index_d;
            attr_out_valid_q <= attr_out_valid_d;
            attr_owner_q     <= attr_owner_d;
            attr_out_type_q  <= attr_out_type_d;
            attr_out_value_q <= attr_out_value_d;
            doc_done_q       <= doc_done_d;
            err_overflow_q   <= err_overflow_d;
            err_underflow_q  <= err_underflow_d;
            err_mismatch_q   <= err_mismatch_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_tag_q[push_ptr] <= bus.element_tag;
            stack_idx_q[push_ptr] <= node_count_q;
        end
    end

    assign bus.node_valid     = node_valid_q;
    assign bus.node_tag       = node_tag_q;
    assign bus.node_index     = node_index_q;
    assign bus.node_parent    = node_parent_q;
    assign bus.node_depth     = node_depth_q;
    assign bus.close_valid    = close_valid_q;
    assign bus.close_index    = close_index_q;
    assign bus.attr_out_valid = attr_out_valid_q;
    assign bus.attr_owner     = attr_owner_q;
    assign bus.attr_out_type  = attr_out_type_q;
    assign bus.attr_out_value = attr_out_value_q;
    assign bus.depth          = depth_q;
    assign bus.doc_done       = doc_done_q;
    assign bus.err_overflow   = err_overflow_q;
    assign bus.err_underflow  = err_underflow_q;
    assign bus.err_mismatch   = err_mismatch_q;
endmodule

// File: tb/tb_element_tree_builder.sv
// Directed scoreboard bench for element_tree_builder: a small reference model
// queues the expected output record for each driven cycle.
`ifndef ELE_TAG_BITES
`define ELE_TAG_BITES 3
`endif
`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 8
`endif
`ifndef TAG_DIV
`define TAG_DIV  3'd1
`define TAG_P    3'd2
`define TAG_BODY 3'd3
`define TAG_A    3'd4
`define TAG_IMG  3'd5
`endif

module tb_element_tree_builder;
    localparam int MAXD = 8;

    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    element_tree_builder_if #(.MAX_DEPTH(MAXD), .NODE_BITS(6)) bus ();

    element_tree_builder #(.MAX_DEPTH(MAXD), .NODE_BITS(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       nv;
        logic [2:0] ntag;
        logic [5:0] nidx;
        logic [5:0] npar;
        logic [3:0] ndep;
        logic       cv;
        logic [5:0] cidx;
        logic       av;
        logic [5:0] aown;
        logic [3:0] atyp;
        logic [7:0] aval;
        logic [3:0] dep;
        logic       done;
        logic       ovf;
        logic       udf;
        logic       mis;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int         m_state;   // 0 run, 1 done, 2 error
    logic [2:0] m_tag[$];
    logic [5:0] m_idx[$];
    logic [5:0] m_count;
    logic [5:0] m_last;
    logic       m_lv;
    logic       m_done, m_ovf, m_udf, m_mis;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_tag.delete();
        m_idx.delete();
        m_count = '0;
        m_last  = '0;
        m_lv    = 1'b0;
        m_done  = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic model(input logic ev, input logic [2:0] tg, input logic cl,
                         input logic av, input logic [3:0] at, input logic [7:0] vl,
                         output exp_t e);
        logic [2:0] ptag;
        e = '0;
        if (m_state == 0) begin
            if (av && m_lv) begin
                e.av = 1'b1; e.aown = m_last; e.atyp = at; e.aval = vl;
            end
            if (ev && !cl) begin
                if (tg != `TAG_IMG && m_tag.size() == MAXD) begin
                    m_ovf = 1'b1; m_state = 2;
                end else begin
                    e.nv = 1'b1; e.ntag = tg; e.nidx = m_count;
                    e.ndep = 4'(m_tag.size());
                    e.npar = (m_idx.size() == 0) ? 6'h3F : m_idx[$];
                    m_last = m_count; m_lv = 1'b1; m_count = m_count + 6'd1;
                    if (tg != `TAG_IMG) begin
                        m_tag.push_back(tg); m_idx.push_back(e.nidx);
                    end
                end
            end else if (ev && cl) begin
                if (m_tag.size() == 0) begin
                    m_udf = 1'b1; m_state = 2;
                end else if (m_tag[$] != tg) begin
                    m_mis = 1'b1; m_state = 2;
                end else begin
                    e.cv = 1'b1; e.cidx = m_idx.pop_back();
                    ptag = m_tag.pop_back();
                    if (m_tag.size() == 0 && ptag == `TAG_BODY) begin
                        m_done = 1'b1; m_state = 1;
                    end
                end
            end
        end
        e.dep = 4'(m_tag.size());
        e.done = m_done; e.ovf = m_ovf; e.udf = m_udf; e.mis = m_mis;
    endtask

    task automatic cmp_out(input exp_t e);
        chk("node_valid", bus.node_valid, e.nv);
        if (e.nv) begin
            chk("node_tag", bus.node_tag, e.ntag);
            chk("node_index", bus.node_index, e.nidx);
            chk("node_parent", bus.node_parent, e.npar);
            chk("node_depth", bus.node_depth, e.ndep);
        end
        chk("close_valid", bus.close_valid, e.cv);
        if (e.cv) chk("close_index", bus.close_index, e.cidx);
        chk("attr_out_valid", bus.attr_out_valid, e.av);
        if (e.av) begin
            chk("attr_owner", bus.attr_owner, e.aown);
            chk("attr_out_type", bus.attr_out_type, e.atyp);
            chk("attr_out_value", bus.attr_out_value, e.aval);
        end
        chk("depth", bus.depth, e.dep);
        chk("doc_done", bus.doc_done, e.done);
        chk("err_overflow", bus.err_overflow, e.ovf);
        chk("err_underflow", bus.err_underflow, e.udf);
        chk("err_mismatch", bus.err_mismatch, e.mis);
    endtask

    task automatic step(input logic ev, input logic [2:0] tg, input logic cl,
                        input logic av, input logic [3:0] at, input logic [7:0] vl);
        exp_t e;
        @(negedge clock);
        if (sb_q.size() > 0) cmp_out(sb_q.pop_front());
        bus.elem_valid      = ev;
        bus.element_tag     = tg;
        bus.is_closing_tag  = cl;
        bus.attr_valid      = av;
        bus.attribute_type  = at;
        bus.attribute_value = vl;
        model(ev, tg, cl, av, at, vl, e);
        sb_q.push_back(e);
    endtask

    task automatic open_tag(input logic [2:0] tg);  step(1'b1, tg, 1'b0, 1'b0, 4'd0, 8'd0); endtask
    task automatic close_tag(input logic [2:0] tg); step(1'b1, tg, 1'b1, 1'b0, 4'd0, 8'd0); endtask
    task automatic attr(input logic [3:0] at, input logic [7:0] vl); step(1'b0, 3'd0, 1'b0, 1'b1, at, vl); endtask
    task automatic idle(); step(1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 8'd0); endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_node_valid"}, bus.node_valid, 0);
        chk({tag, "_node_index"}, bus.node_index, 0);
        chk({tag, "_node_parent"}, bus.node_parent, 0);
        chk({tag, "_close_valid"}, bus.close_valid, 0);
        chk({tag, "_attr_out_valid"}, bus.attr_out_valid, 0);
        chk({tag, "_depth"}, bus.depth, 0);
        chk({tag, "_flags"}, {bus.doc_done, bus.err_overflow, bus.err_underflow, bus.err_mismatch}, 0);
    endtask

    // Asserted between edges so any input driven this cycle is never sampled.
    task automatic do_reset(input string tag);
        #1;
        reset_n = 1'b0;
        bus.elem_valid = 1'b0;
        bus.attr_valid = 1'b0;
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clock);
        chk_zero(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        bus.elem_valid      = 1'b0;
        bus.element_tag     = '0;
        bus.is_closing_tag  = 1'b0;
        bus.attr_valid      = 1'b0;
        bus.attribute_type  = '0;
        bus.attribute_value = '0;
        do_reset("reset");

        // <body><div></div></body>, then inputs ignored in DONE
        open_tag(`TAG_BODY);
        open_tag(`TAG_DIV);
        close_tag(`TAG_DIV);
        close_tag(`TAG_BODY);
        open_tag(`TAG_DIV);
        attr(4'd2, 8'hA5);
        idle();
        chk("done_sticky", bus.doc_done, 1);

        // <body><img> + attribute on the img
        do_reset("rst2");
        open_tag(`TAG_BODY);
        open_tag(`TAG_IMG);
        attr(4'd1, 8'h55);
        idle();
        chk("img_depth", bus.depth, 1);

        // <div></p> mismatch, then everything ignored
        do_reset("rst3");
        open_tag(`TAG_DIV);
        close_tag(`TAG_P);
        open_tag(`TAG_DIV);
        attr(4'd3, 8'h11);
        close_tag(`TAG_DIV);
        idle();
        chk("mismatch_flag", bus.err_mismatch, 1);

        // nine nested divs: eighth fills the stack, ninth overflows
        do_reset("rst4");
        for (int i = 0; i < 9; i++) open_tag(`TAG_DIV);
        open_tag(`TAG_P);
        idle();
        chk("overflow_depth", bus.depth, 8);

        // closing tag first
        do_reset("rst5");
        close_tag(`TAG_DIV);
        open_tag(`TAG_DIV);
        idle();

        // dropped attr before any node, then attr and <p> in the same cycle
        do_reset("rst6");
        attr(4'd4, 8'h99);
        open_tag(`TAG_DIV);
        step(1'b1, `TAG_P, 1'b0, 1'b1, 4'd5, 8'h3C);
        attr(4'd6, 8'hC3);
        close_tag(`TAG_P);
        open_tag(`TAG_A);
        close_tag(`TAG_A);
        close_tag(`TAG_DIV);
        idle();

        // abort at depth 3 with an element in flight, then restart
        do_reset("rst7");
        open_tag(`TAG_BODY);
        open_tag(`TAG_DIV);
        open_tag(`TAG_P);
        idle();
        open_tag(`TAG_A);
        do_reset("midrst");
        idle();
        open_tag(`TAG_BODY);
        idle();
        chk("restart_index", bus.node_index, 0);
        chk("restart_depth", bus.depth, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
